// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C master among NREQ requesters.
// Arbitration is round-robin. The scan starts at rr_ptr and wraps.
// The winner's address and data byte are latched. The block then waits
// for the master to finish and pulses ack_done or ack_err back to the owner.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a transaction that
// gets no m_done within TO_CYCLES cycles. The abort is reported as ack_err.

module i2c_cmd_arbiter #(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = 4096
) (
    input  logic              ck,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_nack,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack_done,
    output logic [NREQ-1:0]   ack_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_param_check
        $error("i2c_cmd_arbiter: NREQ must be 2..8 and TO_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_done_q, ack_done_d;
    logic [NREQ-1:0]   ack_err_q, ack_err_d;
    logic              m_start_q, m_start_d;
    logic [6:0]        m_addr_q, m_addr_d;
    logic [7:0]        m_data_q, m_data_d;

    logic [6:0]        addr_arr [NREQ];
    logic [7:0]        data_arr [NREQ];
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic              in_wait;
    logic              timeout_hit;
    logic              finish;
    logic [PW-1:0]     rr_next;

    // Unpack the per-requester address and data buses into arrays.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            addr_arr[k] = req_addr[k*7 +: 7];
            data_arr[k] = req_data[k*8 +: 8];
        end
    end

    // Round-robin pick: the first set req bit, scanning up from rr_ptr with wrap.
    always_comb begin
        logic [PW:0] pos;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pos        = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (pos >= (PW+1)'(NREQ)) begin
                pos = pos - (PW+1)'(NREQ);
            end
            if (!pick_valid && req[pos[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = pos[PW-1:0];
            end
        end
    end

    assign in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign finish  = in_wait && (m_done || timeout_hit);
    assign rr_next = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Watchdog count: cleared while launching, then counts every waiting cycle.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ISSUE) begin
            to_cnt_d = '0;
        end else if (in_wait) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = in_wait && (to_cnt_q == TW'(TO_CYCLES - 1));

    // Watchdog counter register.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_valid) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (finish) begin
                    state_d = IDLE;
                end else if (m_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: if (finish) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, the owner index and rr_ptr.
    // A real m_done wins over a watchdog expiry in the same cycle.
    always_comb begin
        m_start_d  = 1'b0;
        ack_done_d = '0;
        ack_err_d  = '0;
        gnt_d      = gnt_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == IDLE && pick_valid) begin
            gnt_d     = NREQ'(1) << pick_idx;
            m_start_d = 1'b1;
            m_addr_d  = addr_arr[pick_idx];
            m_data_d  = data_arr[pick_idx];
            owner_d   = pick_idx;
        end else if (finish) begin
            gnt_d    = '0;
            rr_ptr_d = rr_next;
            if (m_done && !m_nack) begin
                ack_done_d = gnt_q;
            end else begin
                ack_err_d = gnt_q;
            end
        end
    end

    // Output, owner and pointer registers.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            m_start_q  <= 1'b0;
            ack_done_q <= '0;
            ack_err_q  <= '0;
            gnt_q      <= '0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            m_start_q  <= m_start_d;
            ack_done_q <= ack_done_d;
            ack_err_q  <= ack_err_d;
            gnt_q      <= gnt_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign m_start  = m_start_q;
    assign m_addr   = m_addr_q;
    assign m_data   = m_data_q;
    assign gnt      = gnt_q;
    assign ack_done = ack_done_q;
    assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed testbench for i2c_cmd_arbiter (NREQ=4, TO_CYCLES=16).
// Expected values are hand-derived from the round-robin order and the
// cycle timing of the IDLE/ISSUE/WAIT_BUSY/WAIT_DONE sequence.

module tb_i2c_cmd_arbiter;

    logic        ck;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic        m_busy;
    logic        m_done;
    logic        m_nack;
    logic        m_start;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic [3:0]  gnt;
    logic [3:0]  ack_done;
    logic [3:0]  ack_err;

    int total = 0;
    int bad   = 0;

    i2c_cmd_arbiter #(
        .NREQ      (4),
        .TO_CYCLES (16)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .m_busy   (m_busy),
        .m_done   (m_done),
        .m_nack   (m_nack),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .gnt      (gnt),
        .ack_done (ack_done),
        .ack_err  (ack_err)
    );

    // Free-running clock with a 10-unit period.
    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    // Drive the master-side handshake inputs.
    task automatic applyStimulus(input logic busy, input logic done, input logic nack);
        m_busy = busy;
        m_done = done;
        m_nack = nack;
    endtask

    // One fast transaction, starting from IDLE with req already driven.
    // Completion comes in WAIT_BUSY, so the master never shows busy.
    task automatic runTxn(input logic [3:0] exp_gnt, input logic [6:0] exp_addr,
                          input logic nack, input logic [3:0] req_after);
        step(1);
        checkOutput("txn_gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("txn_start", 32'(m_start), 32'd1);
        checkOutput("txn_addr", 32'(m_addr), 32'(exp_addr));
        checkOutput("txn_ack_clear", 32'({ack_done, ack_err}), 32'd0);
        req = req_after;
        step(1);
        checkOutput("txn_start_once", 32'(m_start), 32'd0);
        checkOutput("txn_gnt_held", 32'(gnt), 32'(exp_gnt));
        applyStimulus(1'b0, 1'b1, nack);
        step(1);
        checkOutput("txn_ack_done", 32'(ack_done), nack ? 32'd0 : 32'(exp_gnt));
        checkOutput("txn_ack_err", 32'(ack_err), nack ? 32'(exp_gnt) : 32'd0);
        checkOutput("txn_gnt_clr", 32'(gnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Directed scenario sequence.
    initial begin
        logic [3:0] exp_g;
        reset    = 1'b1;
        req      = 4'b0000;
        req_addr = '0;
        req_data = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(2);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_start", 32'(m_start), 32'd0);
        checkOutput("rst_addr", 32'(m_addr), 32'd0);
        checkOutput("rst_data", 32'(m_data), 32'd0);
        checkOutput("rst_acks", 32'({ack_done, ack_err}), 32'd0);
        reset = 1'b0;
        step(1);
        checkOutput("idle_gnt", 32'(gnt), 32'd0);

        // Basic single-requester transaction through WAIT_DONE.
        req_addr[20:14] = 7'h50;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        step(1);
        checkOutput("t1_gnt", 32'(gnt), 32'h4);
        checkOutput("t1_start", 32'(m_start), 32'd1);
        checkOutput("t1_addr", 32'(m_addr), 32'h50);
        checkOutput("t1_data", 32'(m_data), 32'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(1);
        checkOutput("t1_start_once", 32'(m_start), 32'd0);
        step(10);
        checkOutput("t1_no_ack_yet", 32'({ack_done, ack_err}), 32'd0);
        checkOutput("t1_gnt_held", 32'(gnt), 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(1);
        checkOutput("t1_ack_done", 32'(ack_done), 32'h4);
        checkOutput("t1_ack_err", 32'(ack_err), 32'd0);
        checkOutput("t1_gnt_clr", 32'(gnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        req = 4'b0000;
        step(1);
        checkOutput("t1_ack_pulse", 32'(ack_done), 32'd0);

        // All four requesting: the order after reset is 0,1,2,3,0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*7 +: 7] = 7'(8'h10 + i);
            req_data[i*8 +: 8] = 8'(8'hC0 + i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            runTxn(exp_g, 7'(8'h10 + (k % 4)), 1'b0, 4'b1111);
        end

        // NACK for requester 1; waiting requester 2 is served before 1 again.
        req = 4'b0010;
        runTxn(4'b0010, 7'h11, 1'b1, 4'b0110);
        runTxn(4'b0100, 7'h12, 1'b0, 4'b0010);
        runTxn(4'b0010, 7'h11, 1'b0, 4'b0000);

        // Owner 0 drops req and changes its address while it owns the master.
        req = 4'b0001;
        step(1);
        checkOutput("t4_gnt", 32'(gnt), 32'h1);
        checkOutput("t4_addr", 32'(m_addr), 32'h10);
        req = 4'b0000;
        req_addr[6:0] = 7'h7F;
        req_data[7:0] = 8'h3C;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        checkOutput("t4_addr_hold", 32'(m_addr), 32'h10);
        checkOutput("t4_data_hold", 32'(m_data), 32'hC0);
        checkOutput("t4_gnt_hold", 32'(gnt), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(1);
        checkOutput("t4_ack_done", 32'(ack_done), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset while requester 3 is in WAIT_DONE; after release 0 wins.
        req = 4'b1000;
        step(1);
        checkOutput("t5_gnt", 32'(gnt), 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(2);
        reset = 1'b1;
        req = 4'b1001;
        #1;
        checkOutput("t5_async_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_async_start", 32'(m_start), 32'd0);
        checkOutput("t5_async_addr", 32'(m_addr), 32'd0);
        checkOutput("t5_async_data", 32'(m_data), 32'd0);
        checkOutput("t5_async_acks", 32'({ack_done, ack_err}), 32'd0);
        step(2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        runTxn(4'b0001, 7'h7F, 1'b0, 4'b1001);

        // m_done during ISSUE is ignored; the watchdog governs a silent master.
        step(1);
        checkOutput("t6_gnt", 32'(gnt), 32'h8);
        checkOutput("t6_start", 32'(m_start), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(1);
        checkOutput("t6_issue_done_ignored", 32'(ack_done), 32'd0);
        checkOutput("t6_gnt_after_issue", 32'(gnt), 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef I2C_ARB_TIMEOUT_EN
        step(15);
        checkOutput("t6_before_to_gnt", 32'(gnt), 32'h8);
        checkOutput("t6_before_to_err", 32'(ack_err), 32'd0);
        step(1);
        checkOutput("t6_to_err", 32'(ack_err), 32'h8);
        checkOutput("t6_to_done", 32'(ack_done), 32'd0);
        checkOutput("t6_to_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        step(1);
        checkOutput("t6_to_pulse", 32'(ack_err), 32'd0);
`else
        step(40);
        checkOutput("t6_hold_gnt", 32'(gnt), 32'h8);
        checkOutput("t6_hold_acks", 32'({ack_done, ack_err}), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(1);
        checkOutput("t6_late_done", 32'(ack_done), 32'h8);
        checkOutput("t6_late_gnt", 32'(gnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        req = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
